// File: rtl/booth_digit_gen_pkg.sv
// Shared radix-4 Booth definitions: FSM states, zero-window encodings and sel decode helpers.
package booth_pkg;

  typedef enum logic {IDLE, EMIT} booth_state_t;

  localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
  localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

  // Windows 100/101/110 select a negative multiple: the PP is inverted and needs a +1.
  function automatic logic booth_neg(input logic [2:0] sel);
    return (sel == 3'b100) || (sel == 3'b101) || (sel == 3'b110);
  endfunction

  function automatic logic booth_is_zero(input logic [2:0] sel);
    return (sel == BOOTH_ZERO_P) || (sel == BOOTH_ZERO_N);
  endfunction

endpackage

// File: rtl/booth_digit_gen.sv
// Sequential radix-4 Booth recoder streaming one digit per handshake.
// Optional BOOTH_SKIP_ZERO_EN: zero-PP digits before the last are consumed internally, not emitted.
module booth_digit_gen
  import booth_pkg::*;
#(
  parameter  int N    = 10,
  localparam int NDIG = (N + 1) / 2,
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  B_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    sel,
  output logic          neg,
  output logic [IW-1:0] digit_idx,
  output logic          last
);

  localparam int SW = 2 * NDIG + 1;

  booth_state_t      state, state_n;
  logic [SW-1:0]     sr, sr_n;
  logic [IW-1:0]     k, k_n;
  logic              valid_n, last_n, load, adv;
  logic [2*NDIG-1:0] b_ext;

  assign b_ext     = (2*NDIG)'($signed(B_in));
  assign in_ready  = ~rst & ((state == IDLE) | (out_valid & out_ready & last));
  assign sel       = sr[2:0];
  assign digit_idx = k;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    k_n     = k;
    load    = in_valid & in_ready;
    // An EMIT cycle with out_valid low is an internal skip cycle and always advances.
    adv     = (state == EMIT) & (~out_valid | out_ready);
    if (load) begin
      state_n = EMIT;
      sr_n    = {b_ext, 1'b0};
      k_n     = '0;
    end else if (adv) begin
      if (last) begin
        state_n = IDLE;
      end else begin
        sr_n = {sr[SW-1], sr[SW-1], sr[SW-1:2]};
        k_n  = k + 1'b1;
      end
    end
    last_n = (state_n == EMIT) && (k_n == IW'(NDIG - 1));
`ifdef BOOTH_SKIP_ZERO_EN
    valid_n = (state_n == EMIT) & (last_n | ~booth_is_zero(sr_n[2:0]));
`else
    valid_n = (state_n == EMIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      neg       <= 1'b0;
      last      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      k         <= k_n;
      out_valid <= valid_n;
      neg       <= booth_neg(sr_n[2:0]);
      last      <= last_n;
    end
  end

endmodule
